// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the data-memory responder: FSM state
// encoding, word-index width and the idle/error response data value.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Response data returned for stores, errors and after reset.
  localparam logic [31:0] RESP_ZERO = 32'h0000_0000;

  // Number of word-index bits needed to address depth words.
  function automatic int idx_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/data_mem_responder_word_ram.sv
// Word-organised storage with per-byte write enables and a registered read
// port. Write and read share the clock edge; contents are never cleared.
module word_ram #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [3:0]    wr_be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-masked write and registered read, both on the same rising edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) begin
          mem[addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
    if (rd_en) begin
      rd_data <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data-memory responder. A request is decoded and the
// memory accessed at the acceptance edge; the response appears LATENCY
// cycles later and is held until the consumer takes it.
module data_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = idx_width(DEPTH_WORDS);
  // WAIT spends LATENCY-1 edges; the last of them (count 0) enters RESP.
  localparam logic [3:0] CNT_INIT = 4'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  state_t      state;
  logic [3:0]  cnt;
  logic        pend_ok;
  logic        pend_err;

  logic        accept;
  logic        misaligned;
  logic        out_of_range;
  logic        acc_err;
  logic        enter_resp;
  logic        ram_we;
  logic        ram_re;
  logic [AW-1:0] word_idx;
  logic [31:0] ram_rdata;

  assign accept       = req_valid && req_ready;
  assign misaligned   = |req_addr[1:0];
  assign out_of_range = req_addr[31:2] >= 30'(DEPTH_WORDS);
  assign acc_err      = misaligned || out_of_range;
  assign enter_resp   = (state == WAIT) && (cnt == 4'd0);
  assign ram_we       = accept && req_write && !acc_err;
  assign ram_re       = accept && !req_write && !acc_err;
  assign word_idx     = req_addr[AW+1:2];

  word_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_be   (req_be),
    .addr    (word_idx),
    .wr_data (req_wdata),
    .rd_en   (ram_re),
    .rd_data (ram_rdata)
  );

  // Request/response FSM with latency countdown and registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      pend_ok    <= 1'b0;
      pend_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            pend_ok   <= ram_re;
            pend_err  <= acc_err;
            if (LATENCY == 1) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= acc_err;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (enter_resp) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= pend_err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

  // With a one-cycle latency the RAM read lands on the same edge that enters
  // RESP, so the load data is muxed straight from the RAM register; both
  // pend_ok and the RAM output only change at acceptance, i.e. RESP entry.
  if (LATENCY == 1) begin : g_bypass
    assign resp_rdata = pend_ok ? ram_rdata : RESP_ZERO;
  end else begin : g_reg
    logic [31:0] rdata_q;

    // Capture the load word (or zero) when the response becomes visible.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rdata_q <= RESP_ZERO;
      end else if (enter_resp) begin
        rdata_q <= pend_ok ? ram_rdata : RESP_ZERO;
      end
    end

    assign resp_rdata = rdata_q;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Single-outstanding data-memory responder. It serves the load/store port of the MIPS datapath behind a valid/ready request channel and a valid/ready response channel. It holds word-addressed storage with byte enables and returns read data or a write acknowledgement after a fixed, parameterised latency. Misaligned and out-of-range accesses complete with an error flag instead of touching memory.

## Interface
- DEPTH_WORDS, 256: storage size in 32-bit words; power of two, 2..65536.
- LATENCY, 2: cycles from request acceptance to first `resp_valid`; range 1..15.

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_be  input  4  byte enables; bit i covers wdata[8i+7:8i].
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts the response.
- resp_rdata  output  32  load data; 0 for stores and errors.
- resp_err  output  1  access was misaligned or out of range.

## Operation
- FSM states:
  - IDLE: `req_ready`=1. A handshake (`req_valid`&&`req_ready`) moves to WAIT, or to RESP directly when LATENCY=1.
  - WAIT: counts down. On the final count it moves to RESP.
  - RESP: `resp_valid`=1 and outputs are held stable. `resp_ready` returns the FSM to IDLE.
- Only one request is outstanding. `req_ready`=0 in WAIT and RESP, so there is no back-to-back acceptance.
- Error is decided at acceptance:
  - misaligned when req_addr[1:0]≠0;
  - out of range when req_addr[31:2] ≥ DEPTH_WORDS.
- On error:
  - no memory write;
  - `resp_err`=1 and `resp_rdata`=0.
- Store handling:
  - The write commits at the acceptance edge, byte-masked by `req_be`.
  - `req_be`=0 writes nothing and completes normally, with err=0.
- Load handling:
  - The word is read at the acceptance edge and registered.
  - `req_be` is ignored for loads; the full word is returned.
- Word index is req_addr[log2(DEPTH_WORDS)+1:2].
- Storage is not cleared by reset. Contents are X until written.

## Timing
- Reset values:
  - `req_ready`=1;
  - `resp_valid`=0;
  - `resp_rdata`=0;
  - `resp_err`=0;
  - FSM=IDLE;
  - counter=0.
- Acceptance at edge T gives `resp_valid` high in the cycle after edge T+LATENCY-1. The response is therefore visible LATENCY cycles after the accept cycle.
- `resp_valid` stays high until the edge where `resp_ready`=1. `req_ready` rises in the next cycle, so the minimum request period is LATENCY+1 cycles.
- If `resp_ready` is already high when `resp_valid` rises, the response completes in that single cycle.
- `resp_rdata` and `resp_err` change only on entry to RESP or on reset.
- Reset asserted mid-operation:
  - the pending response is discarded;
  - a store accepted before reset stays committed.
- Request inputs are sampled only at the handshake. Their values outside the handshake are don't-care.

## Structure
- Package `mem_resp_pkg` holds:
  - the state enum (IDLE, WAIT, RESP);
  - a function for the word-index width, log2(DEPTH_WORDS);
  - a constant for the error-free zero response.
- Sub-module `word_ram` holds DEPTH_WORDS×32 storage. It has a 4-bit byte-enable write and a registered read, both on the same edge. The top level holds the FSM, the latency counter, error decode and the response registers.

## Test plan
- Store then load: store addr 0x10, wdata 0xDEADBEEF, be 0xF, then load 0x10. Required: rdata 0xDEADBEEF, err 0, `resp_valid` exactly LATENCY cycles after each accept.
- Byte merge: store 0x20 = 0x11223344 with be 0xF, then store 0x20 = 0xAABBCCDD with be 0x5, then load 0x20. Required: rdata 0x11BB33DD.
- Errors:
  - load 0x22 → err 1, rdata 0.
  - store 0x400 with DEPTH 256 → err 1, and a later load of 0x0 is unchanged.
- Backpressure: hold `resp_ready`=0 for 5 cycles after `resp_valid`. Required: rdata, err and valid stay stable, `req_ready` stays 0, and `req_ready` returns 1 the cycle after `resp_ready`.
- LATENCY=1 build: accept a load at cycle 0. Required: `resp_valid` at cycle 1; with `resp_ready` tied 1, sustained throughput is one request per 2 cycles.
- Reset mid-WAIT: store 0x8 = 0x5A5A5A5A, then pulse `reset` low during WAIT. Required: `resp_valid`=0 and `req_ready`=1 after release, and a load of 0x8 returns 0x5A5A5A5A.
